// File: rtl/spi_mem_pkg.sv
// Shared types and SPI command constants for the SPI memory arbiter.
package spi_mem_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} arb_state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Requester-side bus of the SPI memory arbiter: fetch and data req/done pairs.
interface spi_mem_arbiter_if;

  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_done;
  logic [7:0]  fetch_data;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [7:0]  data_wdata;
  logic        data_done;
  logic [7:0]  data_rdata;

  modport master (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
    input  fetch_done, fetch_data, data_done, data_rdata
  );

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
    output fetch_done, fetch_data, data_done, data_rdata
  );

endinterface

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: clock divider, SCLK, MSB-first shift out and MISO capture.
module spi_bit_engine #(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned NBITS   = 40,
  localparam int unsigned CW     = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CW-1:0]    len_i,
  input  logic [NBITS-1:0] data_i,
  input  logic             miso_i,
  output logic             sclk_o,
  output logic             mosi_o,
  output logic             done_o,
  output logic [7:0]       rdata_o
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             active_q;
  logic             sclk_q;
  logic [DW-1:0]    div_q;
  logic [CW-1:0]    bit_q;
  logic [NBITS-1:0] shreg_q;
  logic [7:0]       rx_q;

  logic phase_end, sample, last_bit;

  assign phase_end = active_q && (div_q == DW'(CLK_DIV - 1));
  // MISO is captured only in the first cycle of the SCLK-high phase.
  assign sample    = active_q && sclk_q && (div_q == '0);
  assign last_bit  = (bit_q == len_i - CW'(1));
  assign done_o    = phase_end && sclk_q && last_bit;
  assign rdata_o   = sample ? {rx_q[6:0], miso_i} : rx_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = shreg_q[NBITS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      rx_q     <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= data_i;
    end else if (active_q) begin
      if (sample) rx_q <= rdata_o;
      if (phase_end) begin
        div_q  <= '0;
        sclk_q <= ~sclk_q;
        if (sclk_q) begin
          shreg_q <= {shreg_q[NBITS-2:0], 1'b0};
          bit_q   <= bit_q + CW'(1);
          if (last_bit) active_q <= 1'b0;
        end
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Two-requester arbiter for one SPI memory, one byte READ/WRITE per grant.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin; default is fixed data-over-fetch priority.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned ADDR_BYTES = 3
) (
  input  logic              clk,
  input  logic              rst,
  spi_mem_arbiter_if.slave  bus,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              busy
);

  localparam int unsigned AW    = ADDR_BYTES * 8;
  localparam int unsigned NBITS = 8 + AW + 8;
  localparam int unsigned CW    = $clog2(NBITS + 1);

  arb_state_e state_q;
  owner_e     owner_q, grant;
  logic       we_q, cs_n_q, busy_q;
  logic       fdone_q, ddone_q;
  logic [7:0] fdata_q, drdata_q;
`ifdef SPI_ARB_ROUND_ROBIN_EN
  owner_e     last_q;
`endif

  logic             start, grant_we, eng_done;
  logic [15:0]      grant_addr;
  logic [NBITS-1:0] frame;
  logic [7:0]       eng_rdata;

  always_comb begin
    grant = bus.data_req ? OWN_DATA : OWN_FETCH;
`ifdef SPI_ARB_ROUND_ROBIN_EN
    if (bus.fetch_req && bus.data_req) grant = (last_q == OWN_DATA) ? OWN_FETCH : OWN_DATA;
`endif
  end

  // Fetch is always a read regardless of data_we.
  assign grant_we   = (grant == OWN_DATA) && bus.data_we;
  assign grant_addr = (grant == OWN_DATA) ? bus.data_addr : bus.fetch_addr;
  assign frame      = {grant_we ? SPI_CMD_WRITE : SPI_CMD_READ, AW'(grant_addr),
                       grant_we ? bus.data_wdata : 8'h00};
  assign start      = (state_q == IDLE) && (bus.fetch_req || bus.data_req);

  spi_bit_engine #(
    .CLK_DIV (CLK_DIV),
    .NBITS   (NBITS)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .len_i   (CW'(NBITS)),
    .data_i  (frame),
    .miso_i  (spi_miso),
    .sclk_o  (spi_sclk),
    .mosi_o  (spi_mosi),
    .done_o  (eng_done),
    .rdata_o (eng_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_DATA;
      we_q     <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
      ddone_q  <= 1'b0;
      fdata_q  <= '0;
      drdata_q <= '0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      last_q   <= OWN_DATA;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            owner_q <= grant;
            we_q    <= grant_we;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            last_q  <= grant;
`endif
          end
        end
        SHIFT: begin
          if (eng_done) begin
            cs_n_q  <= 1'b1;
            state_q <= DONE;
            if (owner_q == OWN_FETCH) begin
              fdone_q <= 1'b1;
              fdata_q <= eng_rdata;
            end else begin
              ddone_q <= 1'b1;
              if (!we_q) drdata_q <= eng_rdata;
            end
          end
        end
        DONE: begin
          fdone_q <= 1'b0;
          ddone_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_cs_n       = cs_n_q;
  assign busy           = busy_q;
  assign bus.fetch_done = fdone_q;
  assign bus.fetch_data = fdata_q;
  assign bus.data_done  = ddone_q;
  assign bus.data_rdata = drdata_q;

endmodule
